// File: rtl/instr_decode_queue.sv
// instr_decode_queue
//   Buffers fetched 32-bit instructions in a DEPTH-entry FIFO and decodes the
//   head entry into a registered output stage (fields, extended immediate,
//   instruction class). Valid/ready handshakes on both sides, plus flush.
//
// Optional feature macro: INSTR_DECODE_ILLEGAL_EN
//   Defined   : only opcode 000000 is R; unrecognised opcodes decode as class 11
//               with out_illegal=1 and all fields zero.
//   Undefined : unrecognised opcodes decode as R; out_illegal is tied to 0.
//
// Ports
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready/in_instr/in_pc              : fetch side
//   out_valid/out_ready                           : consumer handshake
//   out_pc, out_opcode, out_rs, out_rt, out_rd,
//   out_shamt, out_funct, out_imm, out_addr_j,
//   out_class (00 R, 01 I, 10 J, 11 illegal),
//   out_illegal                                   : decoded output register
//   count                                         : FIFO occupancy (excl. output reg)
module instr_decode_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [31:0]                      in_instr,
   input  logic [PC_W-1:0]                  in_pc,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [PC_W-1:0]                  out_pc,
   output logic [5:0]                       out_opcode,
   output logic [4:0]                       out_rs,
   output logic [4:0]                       out_rt,
   output logic [4:0]                       out_rd,
   output logic [4:0]                       out_shamt,
   output logic [5:0]                       out_funct,
   output logic [DATA_W-1:0]                out_imm,
   output logic [25:0]                      out_addr_j,
   output logic [1:0]                       out_class,
   output logic                             out_illegal,
   output logic [$clog2(DEPTH+1)-1:0]       count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   localparam logic [1:0] CLS_R   = 2'b00;
   localparam logic [1:0] CLS_I   = 2'b01;
   localparam logic [1:0] CLS_J   = 2'b10;
   localparam logic [1:0] CLS_ILL = 2'b11;

   // FIFO storage and pointers
   logic [31:0]      mem_instr [DEPTH];
   logic [PC_W-1:0]  mem_pc    [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] cnt_q;

   // Output register
   logic              out_valid_q;
   logic [PC_W-1:0]   out_pc_q;
   logic [5:0]        out_opcode_q;
   logic [4:0]        out_rs_q, out_rt_q, out_rd_q, out_shamt_q;
   logic [5:0]        out_funct_q;
   logic [DATA_W-1:0] out_imm_q;
   logic [25:0]       out_addr_j_q;
   logic [1:0]        out_class_q;
   logic              out_illegal_q;

   // Handshake / control
   logic accept, load, fifo_nonempty, pop, push, bypass;

   assign fifo_nonempty = (cnt_q != '0);
   assign in_ready      = (cnt_q < CNT_FULL) && !flush;
   assign accept        = in_valid && in_ready;
   assign load          = !out_valid_q || out_ready;
   assign pop           = load && fifo_nonempty;
   // Bypass only when the FIFO is empty, so ordering is preserved.
   assign bypass        = load && !fifo_nonempty && accept;
   assign push          = accept && !bypass;

   // Decode source: FIFO head when occupied, otherwise the incoming instruction.
   logic [31:0]       src_instr;
   logic [PC_W-1:0]   src_pc;
   logic [5:0]        opc;
   logic              is_j, is_i, is_zext, is_r, is_ill;
   logic [4:0]        dec_rs, dec_rt, dec_rd, dec_shamt;
   logic [5:0]        dec_funct;
   logic [DATA_W-1:0] dec_imm;
   logic [25:0]       dec_addr_j;
   logic [1:0]        dec_class;

   assign src_instr = fifo_nonempty ? mem_instr[rd_ptr_q] : in_instr;
   assign src_pc    = fifo_nonempty ? mem_pc[rd_ptr_q]    : in_pc;
   assign opc       = src_instr[31:26];

   always_comb begin
      is_j    = (opc == 6'b010100) || (opc == 6'b010110);
      is_i    = (opc == 6'b000100) || (opc == 6'b000101) || (opc == 6'b001000) ||
                (opc == 6'b001001) || (opc == 6'b001100) || (opc == 6'b001101) ||
                (opc == 6'b011000);
      is_zext = (opc == 6'b001100) || (opc == 6'b001101);
`ifdef INSTR_DECODE_ILLEGAL_EN
      is_r    = (opc == 6'b000000);
      is_ill  = !(is_j || is_i || is_r);
`else
      is_r    = !(is_j || is_i);
      is_ill  = 1'b0;
`endif

      // Inapplicable fields are forced to zero.
      dec_rs     = '0;
      dec_rt     = '0;
      dec_rd     = '0;
      dec_shamt  = '0;
      dec_funct  = '0;
      dec_imm    = '0;
      dec_addr_j = '0;
      dec_class  = CLS_ILL;

      if (is_j) begin
         dec_class  = CLS_J;
         dec_addr_j = src_instr[25:0];
      end else if (is_i) begin
         dec_class = CLS_I;
         dec_rs    = src_instr[25:21];
         dec_rt    = src_instr[20:16];
         if (is_zext) dec_imm = DATA_W'(src_instr[15:0]);
         else         dec_imm = DATA_W'($signed(src_instr[15:0]));
      end else if (is_r) begin
         dec_class = CLS_R;
         dec_rs    = src_instr[25:21];
         dec_rt    = src_instr[20:16];
         dec_rd    = src_instr[15:11];
         dec_shamt = src_instr[10:6];
         dec_funct = src_instr[5:0];
      end
   end

   // FIFO data: no reset needed, validity is tracked by cnt_q.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr_q] <= in_instr;
         mem_pc[wr_ptr_q]    <= in_pc;
      end
   end

   // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
         else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Output register. Flush only drops validity; reset also clears the fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         out_pc_q      <= '0;
         out_opcode_q  <= '0;
         out_rs_q      <= '0;
         out_rt_q      <= '0;
         out_rd_q      <= '0;
         out_shamt_q   <= '0;
         out_funct_q   <= '0;
         out_imm_q     <= '0;
         out_addr_j_q  <= '0;
         out_class_q   <= CLS_R;
         out_illegal_q <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (load) begin
         if (fifo_nonempty || accept) begin
            out_valid_q   <= 1'b1;
            out_pc_q      <= src_pc;
            out_opcode_q  <= opc;
            out_rs_q      <= dec_rs;
            out_rt_q      <= dec_rt;
            out_rd_q      <= dec_rd;
            out_shamt_q   <= dec_shamt;
            out_funct_q   <= dec_funct;
            out_imm_q     <= dec_imm;
            out_addr_j_q  <= dec_addr_j;
            out_class_q   <= dec_class;
            out_illegal_q <= is_ill;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_pc     = out_pc_q;
   assign out_opcode = out_opcode_q;
   assign out_rs     = out_rs_q;
   assign out_rt     = out_rt_q;
   assign out_rd     = out_rd_q;
   assign out_shamt  = out_shamt_q;
   assign out_funct  = out_funct_q;
   assign out_imm    = out_imm_q;
   assign out_addr_j = out_addr_j_q;
   assign out_class  = out_class_q;
   assign count      = cnt_q;
`ifdef INSTR_DECODE_ILLEGAL_EN
   assign out_illegal = out_illegal_q;
`else
   assign out_illegal = 1'b0;
   logic unused_illegal;
   assign unused_illegal = out_illegal_q;
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
module tb_instr_decode_queue;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]       in_instr;
   logic [PC_W-1:0]   in_pc, out_pc;
   logic [5:0]        out_opcode, out_funct;
   logic [4:0]        out_rs, out_rt, out_rd, out_shamt;
   logic [DATA_W-1:0] out_imm;
   logic [25:0]       out_addr_j;
   logic [1:0]        out_class;
   logic              out_illegal;
   logic [2:0]        count;

   int total = 0;
   int bad   = 0;

   instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pc     (out_pc),
      .out_opcode (out_opcode),
      .out_rs     (out_rs),
      .out_rt     (out_rt),
      .out_rd     (out_rd),
      .out_shamt  (out_shamt),
      .out_funct  (out_funct),
      .out_imm    (out_imm),
      .out_addr_j (out_addr_j),
      .out_class  (out_class),
      .out_illegal(out_illegal),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single cycle, then drop in_valid.
   task automatic send(input logic [31:0] instr, input logic [PC_W-1:0] pc);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_instr = '0; in_pc = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_valid",   out_valid,   0);
      check("rst_count",   count,       0);
      check("rst_ready",   in_ready,    1);
      check("rst_class",   out_class,   0);
      check("rst_imm",     out_imm,     0);
      check("rst_illegal", out_illegal, 0);

      // I, sign-extended
      send(32'h2109FFFF, 32'h100);
      check("addi_valid", out_valid, 1);
      check("addi_class", out_class, 2'b01);
      check("addi_rs",    out_rs,    8);
      check("addi_rt",    out_rt,    9);
      check("addi_imm",   out_imm,   32'hFFFFFFFF);
      check("addi_rd",    out_rd,    0);
      check("addi_shamt", out_shamt, 0);
      check("addi_funct", out_funct, 0);
      check("addi_pc",    out_pc,    32'h100);
      check("addi_count", count,     0);

      // I, zero-extended
      send(32'h30008001, 32'h104);
      check("andi_imm",   out_imm,   32'h00008001);
      check("andi_class", out_class, 2'b01);
      check("andi_pc",    out_pc,    32'h104);

      // I opcode 011000, sign-extended negative
      send(32'h60008000, 32'h108);
      check("op18_imm", out_imm, 32'hFFFF8000);

      // J
      send(32'h50001234, 32'h10C);
      check("j_class", out_class,  2'b10);
      check("j_addr",  out_addr_j, 26'h0001234);
      check("j_rs",    out_rs,     0);
      check("j_imm",   out_imm,    0);

      // R
      send(32'h012A4020, 32'h110);
      check("r_class", out_class,  2'b00);
      check("r_rs",    out_rs,     9);
      check("r_rt",    out_rt,     10);
      check("r_rd",    out_rd,     8);
      check("r_shamt", out_shamt,  0);
      check("r_funct", out_funct,  6'h20);
      check("r_imm",   out_imm,    0);
      check("r_addrj", out_addr_j, 0);

      // Opcode 111111
      send(32'hFFFFFFFF, 32'h114);
`ifdef INSTR_DECODE_ILLEGAL_EN
      check("ill_class",   out_class,   2'b11);
      check("ill_flag",    out_illegal, 1);
      check("ill_rs",      out_rs,      0);
      check("ill_funct",   out_funct,   0);
      check("ill_imm",     out_imm,     0);
`else
      check("ill_class",   out_class,   2'b00);
      check("ill_flag",    out_illegal, 0);
      check("ill_rs",      out_rs,      31);
      check("ill_funct",   out_funct,   6'h3F);
`endif

      // Drain to empty
      tick();
      check("empty_valid", out_valid, 0);

      // Fill: out_ready low, present 6 instructions; only 5 fit (1 output + 4 FIFO).
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_instr = 32'h00000000 | k;
         in_pc    = 32'h200 + 4 * k;
         tick();
      end
      in_valid = 1'b0;
      check("full_count", count,     4);
      check("full_ready", in_ready,  0);
      check("full_valid", out_valid, 1);
      check("full_pc",    out_pc,    32'h200);
      check("full_funct", out_funct, 0);
      tick();
      check("stall_pc", out_pc, 32'h200);
      out_ready = 1'b1;
      #1;
      check("pop_edge_ready", in_ready, 0);
      for (int k = 1; k < 5; k++) begin
         tick();
         check("drain_pc",    out_pc,    32'h200 + 4 * k);
         check("drain_funct", out_funct, k);
         check("drain_ready", in_ready,  1);
      end
      check("drain_count", count, 0);
      tick();
      check("drain_done", out_valid, 0);

      // Simultaneous push and pop keeps count unchanged.
      out_ready = 1'b0;
      send(32'h00000011, 32'h300);
      send(32'h00000012, 32'h304);
      check("pp_count0", count, 1);
      out_ready = 1'b1;
      send(32'h00000013, 32'h308);
      check("pp_count1", count, 1);
      check("pp_pc",     out_pc, 32'h304);
      tick();
      check("pp_pc2", out_pc, 32'h308);
      tick();
      check("pp_empty", out_valid, 0);

      // Flush a full queue while fetch is presenting an instruction.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_instr = 32'h00000020 | k;
         in_pc    = 32'h400 + 4 * k;
         tick();
      end
      check("prefl_count", count, 4);
      in_instr = 32'h0000003F;
      in_pc    = 32'h4F0;
      flush    = 1'b1;
      #1;
      check("flush_ready", in_ready, 0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      check("flush_valid", out_valid, 0);
      check("flush_count", count,     0);
      check("flush_ready2", in_ready, 1);
      tick();
      check("flush_stay", out_valid, 0);
      send(32'h00000015, 32'h500);
      check("postfl_pc",    out_pc,    32'h500);
      check("postfl_funct", out_funct, 6'h15);

      // Reset mid-stream discards everything and clears fields.
      out_ready = 1'b0;
      send(32'h012A4020, 32'h600);
      send(32'h012A4020, 32'h604);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("mrst_valid", out_valid, 0);
      check("mrst_count", count,     0);
      check("mrst_rs",    out_rs,    0);
      check("mrst_pc",    out_pc,    0);
      check("mrst_ready", in_ready,  1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
